// File: rtl/matrix_loader_pkg.sv
// matrix_loader_pkg
//   Shared constants, FSM state type and the B-transpose slot mapping
//   used by the 3x3 matrix loader.
package matrix_loader_pkg;

    localparam int DIM       = 3;
    localparam int NELEM     = DIM * DIM;
    localparam int FRAME_LEN = 2 * NELEM;
    localparam int IDX_W     = 4;

    typedef enum logic [1:0] {
        LOAD_A,
        LOAD_B,
        PRESENT
    } state_t;

    // B arrives row-major (idx = 3k+j) but is stored transposed at slot 3j+k.
    function automatic logic [IDX_W-1:0] b_slot(input logic [IDX_W-1:0] idx);
        logic [IDX_W-1:0] k;
        logic [IDX_W-1:0] j;
        k = idx / IDX_W'(DIM);
        j = idx % IDX_W'(DIM);
        return j * IDX_W'(DIM) + k;
    endfunction

endpackage

// File: rtl/matrix_loader_if.sv
// matrix_loader_if
//   Element stream in (s_*) and operand pair out (m_*) of the loader.
//   master : environment side (drives the element stream, the multiplier's ready)
//   slave  : loader side (accepts elements, presents packed A/B)
//   s_valid/s_ready/s_data/s_last : element stream handshake
//   m_valid/m_ready/m_A/m_B       : packed operand handshake
import matrix_loader_pkg::*;

interface matrix_loader_if #(
    parameter int DATA_W = 8
);
    logic                      s_valid;
    logic                      s_ready;
    logic [DATA_W-1:0]         s_data;
    logic                      s_last;
    logic                      m_valid;
    logic                      m_ready;
    logic [DATA_W*NELEM-1:0]   m_A;
    logic [DATA_W*NELEM-1:0]   m_B;

    modport master (
        output s_valid, s_data, s_last, m_ready,
        input  s_ready, m_valid, m_A, m_B
    );

    modport slave (
        input  s_valid, s_data, s_last, m_ready,
        output s_ready, m_valid, m_A, m_B
    );

endinterface

// File: rtl/matrix_loader_pack_reg.sv
// matrix_loader_pack_reg
//   Nine-slot write-addressed register bank; slot n occupies
//   q_o[n*DATA_W +: DATA_W]. Cleared by synchronous reset.
//   clk, rst : clock, synchronous active-high reset
//   we_i     : write enable
//   addr_i   : slot index 0..8 (larger values are ignored)
//   data_i   : element to write
//   q_o      : packed slot contents
import matrix_loader_pkg::*;

module matrix_loader_pack_reg #(
    parameter int DATA_W = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    we_i,
    input  logic [IDX_W-1:0]        addr_i,
    input  logic [DATA_W-1:0]       data_i,
    output logic [DATA_W*NELEM-1:0] q_o
);

    logic [NELEM-1:0][DATA_W-1:0] slots_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            slots_q <= '0;
        end else if (we_i && (addr_i < IDX_W'(NELEM))) begin
            slots_q[addr_i] <= data_i;
        end
    end

    assign q_o = slots_q;

endmodule

// File: rtl/matrix_loader.sv
// matrix_loader
//   Collects an 18-element stream (A row-major, then B row-major), packs A
//   as-is and B transposed, and presents the pair to the multiplier.
//   clk, rst  : clock, synchronous active-high reset
//   bus       : element stream in / operand pair out (slave side)
//   err       : one-cycle pulse when a frame is dropped for bad s_last framing
//   frame_cnt : number of completed operand handshakes (wraps)
import matrix_loader_pkg::*;

module matrix_loader #(
    parameter int DATA_W = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    matrix_loader_if.slave        bus,
    output logic                  err,
    output logic [15:0]           frame_cnt
);

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic               err_q, err_d;
    logic [15:0]        cnt_q, cnt_d;
    logic               we_a, we_b;
    logic               accept;
    logic               last_idx;

    logic [DATA_W*NELEM-1:0] a_pack, b_pack;

    // Ready is a pure decode of state, masked while reset is asserted.
    assign bus.s_ready = (state_q != PRESENT) && !rst;
    assign bus.m_valid = (state_q == PRESENT);
    assign accept      = bus.s_valid && bus.s_ready;
    assign last_idx    = (idx_q == IDX_W'(NELEM - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= LOAD_A;
            idx_q   <= '0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        err_d   = 1'b0;
        cnt_d   = cnt_q;
        we_a    = 1'b0;
        we_b    = 1'b0;
        case (state_q)
            LOAD_A: begin
                if (accept) begin
                    we_a = 1'b1;
                    if (bus.s_last) begin
                        err_d = 1'b1;
                        idx_d = '0;
                    end else if (last_idx) begin
                        idx_d   = '0;
                        state_d = LOAD_B;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            LOAD_B: begin
                if (accept) begin
                    we_b = 1'b1;
                    if (last_idx) begin
                        idx_d = '0;
                        if (bus.s_last) begin
                            state_d = PRESENT;
                        end else begin
                            err_d   = 1'b1;
                            state_d = LOAD_A;
                        end
                    end else if (bus.s_last) begin
                        err_d   = 1'b1;
                        idx_d   = '0;
                        state_d = LOAD_A;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            PRESENT: begin
                if (bus.m_ready) begin
                    cnt_d   = cnt_q + 16'd1;
                    idx_d   = '0;
                    state_d = LOAD_A;
                end
            end
            default: begin
                state_d = LOAD_A;
                idx_d   = '0;
            end
        endcase
    end

    matrix_loader_pack_reg #(.DATA_W(DATA_W)) u_a_reg (
        .clk    (clk),
        .rst    (rst),
        .we_i   (we_a),
        .addr_i (idx_q),
        .data_i (bus.s_data),
        .q_o    (a_pack)
    );

    matrix_loader_pack_reg #(.DATA_W(DATA_W)) u_b_reg (
        .clk    (clk),
        .rst    (rst),
        .we_i   (we_b),
        .addr_i (b_slot(idx_q)),
        .data_i (bus.s_data),
        .q_o    (b_pack)
    );

    assign bus.m_A  = a_pack;
    assign bus.m_B  = b_pack;
    assign err      = err_q;
    assign frame_cnt = cnt_q;

endmodule
